pad_user_seq: RTL and testbench
===============================

PAD_USER_SEQ -- requirements
Module: pad_user_seq

Interface
REQ-001 Parameter KW2_MAX, default 3: largest supported kernel half-width (kw=7).
REQ-002 Parameter SW_MAX, default 2: largest supported horizontal stride.
REQ-003 Parameters BITS_KW2 default 2, BITS_SW default 1, BITS_COLS default 10, BITS_CIN default 10, BITS_BLK default 10: field widths.
REQ-004 aclk  in  1  sole clock; all state on rising edge.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 aclken  in  1  global clock enable; low freezes all state.
REQ-007 cfg_valid / cfg_ready  in / out  1 / 1  configuration handshake.
REQ-008 cfg_kw2, cfg_sw_1  in  BITS_KW2, BITS_SW  kernel half-width, stride-1.
REQ-009 cfg_cols_1, cfg_cin_1, cfg_blk_1  in  BITS_COLS, BITS_CIN, BITS_BLK  columns-1, input channels-1, row blocks-1.
REQ-010 s_valid / s_ready  in / out  1 / 1  upstream pixel-beat handshake (data travels alongside, outside this block).
REQ-011 m_valid / m_ready  out / in  1 / 1  downstream handshake carrying the user fields.
REQ-012 m_is_config, m_is_cin_last, m_is_cols_1_k2, m_is_col_valid  out  1 each  TUSER flags for the pad filter.
REQ-013 m_kw2, m_sw_1  out  BITS_KW2, BITS_SW  registered config copies, driven on every beat.
REQ-014 done  out  1  one-cycle pulse after the final beat; err  out  1  one-cycle pulse on a rejected config.

Function
REQ-015 The FSM SHALL have the states IDLE, CFG, RUN.
- IDLE: cfg_ready=1, m_valid=0, s_ready=0.
- CFG: emits one config beat; no upstream beat is consumed.
- RUN: streams beats.
REQ-016 An accepted config (cfg_valid & cfg_ready & aclken) SHALL latch every cfg_* field and move IDLE->CFG.
- Exception: a config with kw2>KW2_MAX, sw_1>=SW_MAX or cols_1<kw2 SHALL pulse err for 1 cycle, latch nothing and stay in IDLE.
REQ-017 In CFG the block SHALL drive m_valid=1 with m_is_config=1, all other flags 0, m_kw2/m_sw_1 = the latched values.
- On m_ready & aclken it SHALL move to RUN with all counters cleared.
REQ-018 In RUN, m_valid=s_valid and s_ready=m_ready&aclken (combinational).
- A transfer is s_valid & m_ready & aclken; counters advance only on a transfer.
REQ-019 Counter cin counts 0..cin_1; at wrap it clears and column counter col advances 0..cols_1; at col wrap col clears and blk advances 0..blk_1.
REQ-020 Stride counter str counts 0..sw_1 and advances on each column advance.
- It SHALL clear when col wraps, so each row block restarts at phase 0.
REQ-021 m_is_cin_last SHALL equal (cin==cin_1), m_is_cols_1_k2 SHALL equal (col==cols_1-kw2), m_is_col_valid SHALL equal (str==0), all with m_is_config=0.
REQ-022 kw2=0 SHALL force m_is_cols_1_k2=0.
REQ-023 The transfer with cin==cin_1, col==cols_1, blk==blk_1 SHALL be the last beat.
- On the next edge: return to IDLE and pulse done for exactly 1 cycle.
REQ-024 cin_1=0, cols_1=0 and blk_1=0 SHALL each be legal, giving single-iteration loops.
REQ-025 All flags are combinational from registered state; zero latency from counter state to m_* fields.
REQ-026 While aclken=0 the state and counters SHALL hold; done/err SHALL only pulse on aclken-qualified cycles.
REQ-027 cfg_valid asserted outside IDLE SHALL be ignored (cfg_ready=0).
REQ-028 Counter arithmetic SHALL be unsigned.
- cols_1-kw2 is computed at BITS_COLS width; REQ-016 guarantees it does not underflow.

Reset
REQ-029 Asserting aresetn low at any time SHALL asynchronously force IDLE.
- Counters=0; latched config=0; m_valid=0, s_ready=0, done=0, err=0; cfg_ready=1.
- An in-flight frame is abandoned with no done pulse.
REQ-030 After release, the first config SHALL be accepted on the first aclken-qualified edge.

Verification
REQ-031 Config kw2=1, sw_1=0, cols_1=3, cin_1=1, blk_1=0; source and sink always ready.
- 1 config beat, then 8 beats.
- is_cin_last on beats 1,3,5,7; is_cols_1_k2 on beats 4,5 (col 2); is_col_valid always 1.
- done 1 cycle after beat 7.
REQ-032 Config kw2=2, sw_1=1, cols_1=4, cin_1=0, blk_1=1: is_col_valid pattern 1,0,1,0,1 per block (repeated twice); is_cols_1_k2 at col 2 of each block.
REQ-033 Random s_valid/m_ready/aclken gaps on REQ-031: identical beat sequence; no counter advance on non-transfer cycles.
REQ-034 Config kw2=3 with KW2_MAX=3 is accepted; kw2=4 or cols_1=1 with kw2=2 gives an err pulse, state IDLE, m_valid=0.
REQ-035 aresetn low mid-frame (col=2): outputs reach reset values immediately with no done pulse; a fresh config then restarts at cin=col=blk=0.

Source files
------------

// File: rtl/pad_user_seq.sv
// Generates TUSER flags for the pad filter: one config beat, then cin x cols x blk pixel beats.
// Flags are combinational from counter state; upstream/downstream handshakes pass straight through in RUN.
module pad_user_seq #(
  parameter int KW2_MAX   = 3,
  parameter int SW_MAX    = 2,
  parameter int BITS_KW2  = 2,
  parameter int BITS_SW   = 1,
  parameter int BITS_COLS = 10,
  parameter int BITS_CIN  = 10,
  parameter int BITS_BLK  = 10
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 aclken,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [BITS_KW2-1:0]  cfg_kw2,
  input  logic [BITS_SW-1:0]   cfg_sw_1,
  input  logic [BITS_COLS-1:0] cfg_cols_1,
  input  logic [BITS_CIN-1:0]  cfg_cin_1,
  input  logic [BITS_BLK-1:0]  cfg_blk_1,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_is_config,
  output logic                 m_is_cin_last,
  output logic                 m_is_cols_1_k2,
  output logic                 m_is_col_valid,
  output logic [BITS_KW2-1:0]  m_kw2,
  output logic [BITS_SW-1:0]   m_sw_1,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, CFG, RUN} state_t;

  state_t               state;
  logic [BITS_KW2-1:0]  kw2_r;
  logic [BITS_SW-1:0]   sw_1_r;
  logic [BITS_COLS-1:0] cols_1_r;
  logic [BITS_CIN-1:0]  cin_1_r;
  logic [BITS_BLK-1:0]  blk_1_r;
  logic [BITS_CIN-1:0]  cin;
  logic [BITS_COLS-1:0] col;
  logic [BITS_BLK-1:0]  blk;
  logic [BITS_SW-1:0]   str;

  logic                 cfg_bad;
  logic [BITS_COLS-1:0] cols_k2;
  logic                 cin_wrap;
  logic                 col_wrap;
  logic                 blk_wrap;

  // cols_1 >= kw2 is enforced at config time, so this never underflows
  assign cfg_bad  = (int'(cfg_kw2) > KW2_MAX) || (int'(cfg_sw_1) >= SW_MAX) ||
                    (cfg_cols_1 < BITS_COLS'(cfg_kw2));
  assign cols_k2  = cols_1_r - BITS_COLS'(kw2_r);
  assign cin_wrap = (cin == cin_1_r);
  assign col_wrap = (col == cols_1_r);
  assign blk_wrap = (blk == blk_1_r);

  always_comb begin
    cfg_ready      = (state == IDLE);
    m_valid        = (state == CFG) || ((state == RUN) && s_valid);
    s_ready        = (state == RUN) && m_ready && aclken;
    m_is_config    = (state == CFG);
    m_is_cin_last  = (state == RUN) && cin_wrap;
    m_is_cols_1_k2 = (state == RUN) && (kw2_r != '0) && (col == cols_k2);
    m_is_col_valid = (state == RUN) && (str == '0);
    m_kw2          = kw2_r;
    m_sw_1         = sw_1_r;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      kw2_r    <= '0;
      sw_1_r   <= '0;
      cols_1_r <= '0;
      cin_1_r  <= '0;
      blk_1_r  <= '0;
      cin      <= '0;
      col      <= '0;
      blk      <= '0;
      str      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // done/err are single-cycle pulses raised only by enabled events
      done <= 1'b0;
      err  <= 1'b0;
      if (aclken) begin
        case (state)
          IDLE: begin
            if (cfg_valid) begin
              if (cfg_bad) begin
                err <= 1'b1;
              end else begin
                kw2_r    <= cfg_kw2;
                sw_1_r   <= cfg_sw_1;
                cols_1_r <= cfg_cols_1;
                cin_1_r  <= cfg_cin_1;
                blk_1_r  <= cfg_blk_1;
                state    <= CFG;
              end
            end
          end
          CFG: begin
            if (m_ready) begin
              cin   <= '0;
              col   <= '0;
              blk   <= '0;
              str   <= '0;
              state <= RUN;
            end
          end
          RUN: begin
            if (s_valid && m_ready) begin
              if (cin_wrap) begin
                cin <= '0;
                if (col_wrap) begin
                  col <= '0;
                  str <= '0;
                  if (blk_wrap) begin
                    blk   <= '0;
                    state <= IDLE;
                    done  <= 1'b1;
                  end else begin
                    blk <= blk + 1'b1;
                  end
                end else begin
                  col <= col + 1'b1;
                  str <= (str == sw_1_r) ? '0 : str + 1'b1;
                end
              end else begin
                cin <= cin + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pad_user_seq.sv
// Randomized bench for pad_user_seq against a nested-loop beat-list model of each frame.
module tb_pad_user_seq;
  localparam int BK = 3;
  localparam int BS = 1;
  localparam int BC = 10;
  localparam int BI = 10;
  localparam int BB = 10;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          aclken = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [BK-1:0] cfg_kw2 = '0;
  logic [BS-1:0] cfg_sw_1 = '0;
  logic [BC-1:0] cfg_cols_1 = '0;
  logic [BI-1:0] cfg_cin_1 = '0;
  logic [BB-1:0] cfg_blk_1 = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_is_config, m_is_cin_last, m_is_cols_1_k2, m_is_col_valid;
  logic [BK-1:0] m_kw2;
  logic [BS-1:0] m_sw_1;
  logic          done, err;

  pad_user_seq #(
    .KW2_MAX(3), .SW_MAX(2), .BITS_KW2(BK), .BITS_SW(BS),
    .BITS_COLS(BC), .BITS_CIN(BI), .BITS_BLK(BB)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kw2(cfg_kw2), .cfg_sw_1(cfg_sw_1), .cfg_cols_1(cfg_cols_1),
    .cfg_cin_1(cfg_cin_1), .cfg_blk_1(cfg_blk_1),
    .s_valid(s_valid), .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready),
    .m_is_config(m_is_config), .m_is_cin_last(m_is_cin_last),
    .m_is_cols_1_k2(m_is_cols_1_k2), .m_is_col_valid(m_is_col_valid),
    .m_kw2(m_kw2), .m_sw_1(m_sw_1), .done(done), .err(err)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic cfg;
    logic cl;
    logic k2;
    logic cv;
  } beat_t;

  beat_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected beat list: config beat, then every (blk, col, cin) in loop order
  function automatic void build(input int kw2, input int sw, input int cols, input int cin, input int blk);
    beat_t b;
    exp_q.delete();
    b = '{cfg: 1'b1, cl: 1'b0, k2: 1'b0, cv: 1'b0};
    exp_q.push_back(b);
    for (int bk = 0; bk <= blk; bk++)
      for (int c = 0; c <= cols; c++)
        for (int i = 0; i <= cin; i++) begin
          b.cfg = 1'b0;
          b.cl  = (i == cin);
          b.k2  = (kw2 != 0) && (c == cols - kw2);
          b.cv  = ((c % (sw + 1)) == 0);
          exp_q.push_back(b);
        end
  endfunction

  task automatic run_frame(input int kw2, input int sw, input int cols, input int cin,
                           input int blk, input bit gaps, input int abort_at);
    int    n = 0;
    int    budget = 0;
    bit    accepted = 1'b0;
    bit    sv, mr, en, xfer;
    beat_t front;
    build(kw2, sw, cols, cin, blk);
    while (!accepted) begin
      @(negedge aclk);
      en = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      cfg_valid = 1'b1;
      cfg_kw2 = BK'(kw2); cfg_sw_1 = BS'(sw); cfg_cols_1 = BC'(cols);
      cfg_cin_1 = BI'(cin); cfg_blk_1 = BB'(blk);
      aclken = en; s_valid = 1'b1; m_ready = 1'b1;
      #1;
      check("idle_cfg_ready", 32'(cfg_ready), 32'd1);
      check("idle_m_valid", 32'(m_valid), 32'd0);
      check("idle_s_ready", 32'(s_ready), 32'd0);
      accepted = en;
      budget++;
      if (budget > 200) begin
        check("cfg_timeout", 32'd0, 32'd1);
        return;
      end
    end
    budget = 0;
    while (exp_q.size() != 0) begin
      @(negedge aclk);
      sv = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      mr = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      en = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      cfg_valid = gaps ? ($urandom_range(0, 1) != 0) : 1'b0;
      s_valid = sv; m_ready = mr; aclken = en;
      #1;
      front = exp_q[0];
      check("done_early", 32'(done), 32'd0);
      check("busy_cfg_ready", 32'(cfg_ready), 32'd0);
      check("m_valid", 32'(m_valid), front.cfg ? 32'd1 : 32'(sv));
      check("s_ready", 32'(s_ready), front.cfg ? 32'd0 : 32'(mr & en));
      if (front.cfg || sv) begin
        check("flags", 32'({m_is_config, m_is_cin_last, m_is_cols_1_k2, m_is_col_valid}), 32'(front));
        check("m_kw2", 32'(m_kw2), 32'(kw2));
        check("m_sw_1", 32'(m_sw_1), 32'(sw));
      end
      xfer = front.cfg ? (mr & en) : (sv & mr & en);
      if (xfer) begin
        void'(exp_q.pop_front());
        n++;
        if (n == abort_at) return;
      end
      budget++;
      if (budget > 3000) begin
        check("beat_timeout", 32'd0, 32'd1);
        return;
      end
    end
    @(negedge aclk);
    cfg_valid = 1'b0; s_valid = 1'b1; m_ready = 1'b1; aclken = 1'b1;
    #1;
    check("done_pulse", 32'(done), 32'd1);
    check("end_err", 32'(err), 32'd0);
    check("end_cfg_ready", 32'(cfg_ready), 32'd1);
    check("end_m_valid", 32'(m_valid), 32'd0);
    @(negedge aclk);
    #1;
    check("done_clear", 32'(done), 32'd0);
  endtask

  task automatic bad_cfg(input int kw2, input int cols);
    @(negedge aclk);
    cfg_valid = 1'b1; cfg_kw2 = BK'(kw2); cfg_sw_1 = '0; cfg_cols_1 = BC'(cols);
    cfg_cin_1 = '0; cfg_blk_1 = '0; aclken = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    #1;
    check("bad_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge aclk);
    cfg_valid = 1'b0;
    #1;
    check("err_pulse", 32'(err), 32'd1);
    check("err_m_valid", 32'(m_valid), 32'd0);
    check("err_cfg_ready", 32'(cfg_ready), 32'd1);
    @(negedge aclk);
    #1;
    check("err_clear", 32'(err), 32'd0);
    check("err_idle_m_valid", 32'(m_valid), 32'd0);
  endtask

  task automatic reset_mid_frame();
    // config + 4 beats accepted leaves the sequencer at col 2, cin 0
    run_frame(1, 0, 3, 1, 0, 1'b0, 5);
    @(posedge aclk);
    #1;
    check("pre_rst_k2", 32'(m_is_cols_1_k2), 32'd1);
    #1;
    aresetn = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_m_kw2", 32'(m_kw2), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      #1;
      check("rst_no_done", 32'(done), 32'd0);
    end
    run_frame(1, 0, 3, 1, 0, 1'b0, -1);
  endtask

  initial begin
    #1;
    check("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_s_ready", 32'(s_ready), 32'd0);
    check("reset_done_err", 32'({done, err}), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    run_frame(1, 0, 3, 1, 0, 1'b0, -1);
    run_frame(2, 1, 4, 0, 1, 1'b0, -1);
    for (int i = 0; i < 3; i++) run_frame(1, 0, 3, 1, 0, 1'b1, -1);
    run_frame(3, 0, 3, 0, 0, 1'b0, -1);
    run_frame(0, 1, 3, 1, 1, 1'b1, -1);
    run_frame(0, 0, 0, 0, 0, 1'b0, -1);
    bad_cfg(4, 5);
    bad_cfg(2, 1);
    run_frame(2, 1, 2, 0, 0, 1'b0, -1);
    reset_mid_frame();
    for (int i = 0; i < 6; i++) begin
      int kw2, sw, cols, cin, blk;
      kw2  = int'($urandom_range(0, 3));
      sw   = int'($urandom_range(0, 1));
      cols = kw2 + int'($urandom_range(0, 4));
      cin  = int'($urandom_range(0, 2));
      blk  = int'($urandom_range(0, 2));
      run_frame(kw2, sw, cols, cin, blk, 1'b1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
